aes_key_sched_ctrl: RTL and testbench

- Iterative AES-128 key-schedule controller that sits in front of the pipelined AES/GCM datapath.
- Accepts a 128-bit cipher key over a valid/ready handshake and expands one round key per cycle through a single shared round-expansion unit.
- Holds the full 1408-bit schedule stable for the pipeline stages, which consume it as i_key_schedule.
- Provides an epoch tag so downstream logic can detect a key change.

---
 rtl/aes_pkg.sv | 87 ++++++++
 rtl/aes_key_round.sv | 20 ++
 rtl/aes_key_sched_ctrl.sv | 108 ++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Package     : aes_pkg
// Description : Shared AES-128 key-expansion definitions. Provides the S-box,
//               the round-constant table, round-key and schedule typedefs,
//               a single-round key-expansion function and a full-schedule
//               helper (fn_key_expansion) for existing software-style users.
//               Every user of the key schedule goes through the same S-box.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int N_ROUNDS = 10;
    localparam int SCHED_W  = 1408;

    // Bit 0 is the MSB of byte 0; word 0 occupies bits [0:31].
    typedef logic [0:127]         round_key_t;
    typedef logic [0:SCHED_W-1]   key_sched_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } ks_state_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Index 0 is unused (slot 0 is the cipher key itself).
    localparam logic [7:0] RCON [0:10] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [0:31] fn_sub_word(input logic [0:31] w);
        return {SBOX[w[0:7]], SBOX[w[8:15]], SBOX[w[16:23]], SBOX[w[24:31]]};
    endfunction

    function automatic round_key_t fn_key_round(input round_key_t prev, input logic [7:0] rcon);
        logic [0:31] w0;
        logic [0:31] w1;
        logic [0:31] w2;
        logic [0:31] w3;
        logic [0:31] t;
        w0 = prev[0:31];
        w1 = prev[32:63];
        w2 = prev[64:95];
        w3 = prev[96:127];
        // RotWord moves byte 0 of w3 to the end before substitution.
        t  = fn_sub_word({w3[8:31], w3[0:7]}) ^ {rcon, 24'h000000};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic key_sched_t fn_key_expansion(input round_key_t key);
        key_sched_t s;
        round_key_t rk;
        rk         = key;
        s          = '0;
        s[0 +: 128] = key;
        for (int r = 1; r <= N_ROUNDS; r++) begin
            rk               = fn_key_round(rk, RCON[r]);
            s[128*r +: 128] = rk;
        end
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_round.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_round
// Description : Purely combinational AES-128 round-key expansion step.
//               Ports: prev_key (previous round key), rcon (round constant),
//                      next_key (following round key).
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_round
    import aes_pkg::*;
(
    input  round_key_t  prev_key,
    input  logic [7:0]  rcon,
    output round_key_t  next_key
);

    assign next_key = fn_key_round(prev_key, rcon);

endmodule
`default_nettype wire

// File: rtl/aes_key_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_sched_ctrl
// Description : Iterative AES-128 key-schedule controller. Accepts a cipher
//               key on a valid/ready handshake, expands one round key per
//               cycle through a single shared aes_key_round instance, and
//               holds the full 11-slot schedule stable for the datapath.
//               Ports: clk, rst_n (sync, active-low), i_key_valid/i_key/
//                      o_key_ready (key handshake), i_flush (sync abort),
//                      o_key_schedule (round key r at bits [128r +: 128]),
//                      o_sched_valid, o_busy, o_epoch (completed-key count).
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_sched_ctrl #(
    parameter int N_ROUNDS = 10,
    parameter int KEY_W    = 128,
    parameter int EPOCH_W  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_key_valid,
    input  logic [0:KEY_W-1]              i_key,
    output logic                          o_key_ready,
    input  logic                          i_flush,
    output logic [0:(N_ROUNDS+1)*KEY_W-1] o_key_schedule,
    output logic                          o_sched_valid,
    output logic                          o_busy,
    output logic [EPOCH_W-1:0]            o_epoch
);

    import aes_pkg::*;

    if (N_ROUNDS != 10 || KEY_W != 128) begin : g_bad_cfg
        $error("aes_key_sched_ctrl supports only AES-128 (N_ROUNDS=10, KEY_W=128)");
    end

    localparam logic [3:0] LAST_ROUND = 4'(N_ROUNDS);

    ks_state_t   state;
    logic [3:0]  rcnt;
    round_key_t  slot [0:N_ROUNDS];
    round_key_t  prev_key;
    round_key_t  next_key;
    logic [7:0]  round_rcon;
    logic        accept;

    // Ready is combinational so a flush in the same cycle blocks the handshake.
    assign o_key_ready = rst_n && (state != ST_EXPAND) && !i_flush;
    assign accept      = i_key_valid && o_key_ready;

    // rcnt is at least 1 whenever the expansion result is actually stored.
    assign prev_key   = slot[rcnt - 4'd1];
    assign round_rcon = RCON[rcnt];

    aes_key_round u_round (
        .prev_key (prev_key),
        .rcon     (round_rcon),
        .next_key (next_key)
    );

    for (genvar r = 0; r <= N_ROUNDS; r++) begin : g_pack
        assign o_key_schedule[KEY_W*r +: KEY_W] = slot[r];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            rcnt          <= '0;
            o_sched_valid <= 1'b0;
            o_busy        <= 1'b0;
            o_epoch       <= '0;
            for (int r = 0; r <= N_ROUNDS; r++) begin
                slot[r] <= '0;
            end
        end else if (i_flush) begin
            // Epoch deliberately survives a flush.
            state         <= ST_IDLE;
            rcnt          <= '0;
            o_sched_valid <= 1'b0;
            o_busy        <= 1'b0;
            for (int r = 0; r <= N_ROUNDS; r++) begin
                slot[r] <= '0;
            end
        end else if (accept) begin
            // Uncomputed slots are zeroed so no stale round key leaks out.
            slot[0] <= i_key;
            for (int r = 1; r <= N_ROUNDS; r++) begin
                slot[r] <= '0;
            end
            rcnt          <= 4'd1;
            state         <= ST_EXPAND;
            o_sched_valid <= 1'b0;
            o_busy        <= 1'b1;
        end else if (state == ST_EXPAND) begin
            slot[rcnt] <= next_key;
            if (rcnt == LAST_ROUND) begin
                state         <= ST_DONE;
                o_sched_valid <= 1'b1;
                o_busy        <= 1'b0;
                o_epoch       <= o_epoch + 1'b1;
            end else begin
                rcnt <= rcnt + 4'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_key_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_key_sched_ctrl
// Description : Self-checking bench for aes_key_sched_ctrl. A behavioural
//               model derives the S-box from GF(2^8) arithmetic and expands
//               keys word-by-word; a compare process checks every output on
//               every falling edge. Directed scenarios add literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_key_sched_ctrl;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           i_key_valid = 1'b0;
    logic [0:127]   i_key = '0;
    logic           o_key_ready;
    logic           i_flush = 1'b0;
    logic [0:1407]  o_key_schedule;
    logic           o_sched_valid;
    logic           o_busy;
    logic [3:0]     o_epoch;

    int compared   = 0;
    int mismatched = 0;

    aes_key_sched_ctrl #(.N_ROUNDS(10), .KEY_W(128), .EPOCH_W(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_key_valid    (i_key_valid),
        .i_key          (i_key),
        .o_key_ready    (o_key_ready),
        .i_flush        (i_flush),
        .o_key_schedule (o_key_schedule),
        .o_sched_valid  (o_sched_valid),
        .o_busy         (o_busy),
        .o_epoch        (o_epoch)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0] sb [0:255];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            if (x != 0) begin
                for (int y = 1; y < 256; y++) begin
                    if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
                end
            end
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [0:1407] f_expand(input logic [0:127] k);
        logic [31:0]   w [0:43];
        logic [31:0]   t;
        logic [7:0]    rc = 8'h01;
        logic [0:1407] s;
        for (int i = 0; i < 4; i++) w[i] = k[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) s[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return s;
    endfunction

    // m_mode: 0 idle, 1 expanding, 2 done; m_prog = highest slot computed so far
    logic [0:1407] m_full = '0;
    int            m_mode = 0;
    int            m_prog = 0;
    logic [3:0]    m_epoch = 4'd0;
    bit            m_started = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_started <= 1'b1;
            m_mode    <= 0;
            m_prog    <= 0;
            m_epoch   <= 4'd0;
        end else if (i_flush) begin
            m_mode <= 0;
            m_prog <= 0;
        end else if (i_key_valid && m_mode != 1) begin
            m_full <= f_expand(i_key);
            m_mode <= 1;
            m_prog <= 0;
        end else if (m_mode == 1) begin
            if (m_prog == 9) begin
                m_mode  <= 2;
                m_epoch <= m_epoch + 4'd1;
            end
            m_prog <= m_prog + 1;
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_started) begin
            chk("key_ready", 128'(o_key_ready), 128'(rst_n && m_mode != 1 && !i_flush));
            chk("sched_valid", 128'(o_sched_valid), 128'(m_mode == 2));
            chk("busy", 128'(o_busy), 128'(m_mode == 1));
            chk("epoch", 128'(o_epoch), 128'(m_epoch));
            for (int r = 0; r < 11; r++) begin
                chk($sformatf("slot%0d", r), o_key_schedule[128*r +: 128],
                    (m_mode != 0 && r <= m_prog) ? m_full[128*r +: 128] : 128'h0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_accept(input logic [0:127] k);
        bit done = 1'b0;
        i_key       = k;
        i_key_valid = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            if (o_key_ready) done = 1'b1;
            else @(negedge clk);
        end
        if (!done) begin
            compared++;
            mismatched++;
            $display("FAIL accept_timeout: got ready=0 required ready=1");
        end
        @(posedge clk);
        #1;
        i_key_valid = 1'b0;
    endtask

    task automatic wait_valid();
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = o_sched_valid;
        end
        if (!ok) begin
            compared++;
            mismatched++;
            $display("FAIL valid_timeout: got sched_valid=0 required 1");
        end
    endtask

    localparam logic [0:127] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    initial begin
        logic [0:127] kb;
        int n;
        build_sbox();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_epoch", 128'(o_epoch), 128'h0);
        chk("reset_sched0", o_key_schedule[0 +: 128], 128'h0);

        // FIPS-197 vector
        do_accept(FIPS_KEY);
        wait_valid();
        chk("fips_slot1", o_key_schedule[128 +: 128], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("fips_slot10", o_key_schedule[1280 +: 128], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("fips_epoch", 128'(o_epoch), 128'd1);

        // All-zero key, accepted straight from DONE
        do_accept(128'h0);
        wait_valid();
        chk("zero_slot1", o_key_schedule[128 +: 128], 128'h62636363626363636263636362636363);
        chk("zero_slot10", o_key_schedule[1280 +: 128], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // Backpressure: second key offered at T+3 and held
        do_accept({$urandom, $urandom, $urandom, $urandom});
        repeat (3) @(posedge clk);
        #1;
        kb          = {$urandom, $urandom, $urandom, $urandom};
        i_key       = kb;
        i_key_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!o_key_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("bp_stall_cycles", 128'(n), 128'd7);
        chk("bp_first_done", 128'(o_sched_valid), 128'd1);
        @(posedge clk);
        #1 i_key_valid = 1'b0;
        @(negedge clk);
        chk("bp_valid_drop", 128'(o_sched_valid), 128'd0);
        wait_valid();
        chk("bp_slot0", o_key_schedule[0 +: 128], 128'(kb));
        chk("bp_epoch", 128'(o_epoch), 128'd4);

        // Flush at rcnt = 5 with a simultaneous key offer
        do_accept(FIPS_KEY);
        repeat (4) @(posedge clk);
        #1;
        i_flush     = 1'b1;
        i_key_valid = 1'b1;
        i_key       = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk);
        #1;
        i_flush     = 1'b0;
        i_key_valid = 1'b0;
        @(negedge clk);
        chk("flush_busy", 128'(o_busy), 128'd0);
        chk("flush_slot0", o_key_schedule[0 +: 128], 128'h0);
        chk("flush_epoch", 128'(o_epoch), 128'd4);

        // Reset mid-expansion
        do_accept({$urandom, $urandom, $urandom, $urandom});
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_epoch", 128'(o_epoch), 128'd0);
        chk("rst_busy", 128'(o_busy), 128'd0);
        do_accept(FIPS_KEY);
        wait_valid();
        chk("rst_fips_slot10", o_key_schedule[1280 +: 128], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("rst_fips_epoch", 128'(o_epoch), 128'd1);

        // Epoch wrap: 16 back-to-back random keys accepted from DONE
        for (int k = 0; k < 16; k++) begin
            do_accept({$urandom, $urandom, $urandom, $urandom});
            wait_valid();
            if (k == 14) chk("wrap_epoch_zero", 128'(o_epoch), 128'd0);
        end
        chk("wrap_epoch_end", 128'(o_epoch), 128'd1);

        // Randomized traffic; the compare process checks every cycle
        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            #1;
            rst_n       = ($urandom_range(0, 99) != 0);
            i_flush     = ($urandom_range(0, 29) == 0);
            i_key_valid = ($urandom_range(0, 3) == 0);
            i_key       = {$urandom, $urandom, $urandom, $urandom};
        end
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        i_flush     = 1'b0;
        i_key_valid = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
